enc4to2_serial: RTL and testbench
=================================

# enc4to2_serial

Sequential 4-to-2 priority encoder, the encode-side counterpart of the lab's 2-to-4 decoder. It latches request lines D[3:0] into a sticky pending register. It presents the highest-priority pending index on A[1:0] with valid V, and holds each code until the consumer acknowledges with Rdy. Multiple simultaneous requests drain one code per handshake. It sits between raw request/interrupt lines and any logic that needs a binary index, such as a dec2to4 driving grant lines.

## Interface
- PRIO_HIGH, default 1: 1 = D[3] highest priority; 0 = D[0] highest priority.
- clk  input  1  rising-edge clock; only clock in the block.
- rst_n  input  1  reset, asynchronous, active-low; one clock, no other reset.
- En  input  1  capture enable; D is ignored when En=0.
- D  input  4  request lines, multi-hot allowed, sampled on rising edge.
- Rdy  input  1  consumer acknowledge; handshake completes on an edge with V=1 and Rdy=1.
- A  output  2  encoded index of the currently presented request.
- V  output  1  A is valid.
- Pend  output  4  pending-request register, including the bit currently presented.

## Operation
- Pending update each edge: Pend <= (Pend & ~clr) | (En ? D : 4'b0000).
  - clr is one-hot of A when V=1 and Rdy=1, else 0.
  - Set wins over clear on the same bit.
- FSM states IDLE and HOLD.
- IDLE (V=0):
  - If Pend != 0, load A with the priority winner of Pend, set V=1, go to HOLD.
  - Else stay in IDLE.
  - The selection uses the registered Pend, not D.
- HOLD (V=1):
  - If Rdy=0, A, V and state are unchanged.
  - If Rdy=1 and (Pend & ~clr) != 0, load A with the winner of the remaining Pend, V stays 1, stay in HOLD.
  - If Rdy=1 and nothing remains, V=0, go to IDLE.
- "Remaining" excludes same-edge captures. Requests captured on the handshake edge are seen one cycle later, via IDLE or the next HOLD evaluation.
- No preemption: a higher-priority request arriving during HOLD does not change A until the handshake.
- A request re-asserted on the bit being acknowledged stays in Pend and is presented again later.
- Rdy while V=0 is ignored.
- D=0 or En=0 adds nothing; existing Pend still drains.

## Timing
- Reset values: A=2'b00, V=0, Pend=4'b0000, state IDLE.
  - Takes effect immediately on rst_n falling, including mid-handshake.
  - Any pending requests are discarded.
- First valid after reset release: earliest one cycle after the first capturing edge.
- Capture latency: D captured at edge t gives V=1 and A valid after edge t+1 when idle.
- Throughput: one code per cycle when Rdy is held high and Pend holds multiple bits.
  - Example: Pend=1111 drains in 4 consecutive handshakes.
- A and V are registered outputs, glitch-free, stable between edges.
- Pend updates on the same edge as the FSM.

## Structure
- Package enc_pkg:
  - FSM state type (IDLE, HOLD).
  - Width constants N_REQ=4, IDX_W=2.
- One combinational sub-module, prio_enc4.
  - Inputs: 4-bit request vector and the PRIO_HIGH parameter.
  - Outputs: 2-bit index and an any-flag.
  - Used for both the IDLE load and the HOLD reload.
- Top level holds the Pend register, FSM and output registers.

## Test plan
- Single request:
  - Stimulus: reset, then En=1, D=0100 for one cycle, Rdy=1.
  - Response: V=1, A=10 one cycle after capture; one cycle later V=0, Pend=0000.
- Multi-hot drain:
  - Stimulus: D=1011 in one cycle, PRIO_HIGH=1, Rdy held 1.
  - Response: A sequence 11, 01, 00 on consecutive cycles, then V=0.
  - With PRIO_HIGH=0 the sequence is 00, 01, 11.
- Backpressure:
  - Stimulus: D=0010 captured, Rdy=0 for 5 cycles, D=1000 arriving mid-hold.
  - Response: A=01 held, V=1 throughout, Pend=1010.
  - After Rdy=1, next code is A=11.
- Set/clear collision:
  - Stimulus: while A=10, V=1, assert Rdy=1 with En=1, D=0100 on the same edge.
  - Response: Pend[2] stays 1; A=10 is presented again.
- En gating:
  - Stimulus: En=0, D=1111 for 3 cycles.
  - Response: Pend=0000, V=0.
- Async reset mid-operation:
  - Stimulus: Pend=1100, V=1, then drop rst_n between edges.
  - Response: V=0, A=00, Pend=0000 immediately; no outputs until a new capture.

Source files
------------

// File: rtl/enc4to2_serial_pkg.sv
// enc_pkg: shared widths and FSM state encoding for the serial 4-to-2 encoder
package enc_pkg;
    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t HOLD = 1'b1;
endpackage

// File: rtl/enc4to2_serial_prio_enc4.sv
// prio_enc4: combinational 4-bit priority encoder with selectable direction
import enc_pkg::*;
module prio_enc4 #(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    // pick the winning index; with no request the index is 0
    always_comb begin
        any = |req;
        idx = PRIO_HIGH ? (req[3] ? 2'd3 : req[2] ? 2'd2 : req[1] ? 2'd1 : 2'd0)
                        : (req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : req[3] ? 2'd3 : 2'd0);
    end
endmodule

// File: rtl/enc4to2_serial.sv
// enc4to2_serial: sticky request register drained one index per handshake
import enc_pkg::*;
module enc4to2_serial #(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic [N_REQ-1:0] D,
    input  logic             Rdy,
    output logic [IDX_W-1:0] A,
    output logic             V,
    output logic [N_REQ-1:0] Pend
);
    state_t           state;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] remain;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;

    // acknowledged bit is cleared; same-edge captures are not part of remain
    always_comb begin
        clr    = (V && Rdy) ? (N_REQ'(1) << A) : '0;
        remain = Pend & ~clr;
    end

    prio_enc4 #(.PRIO_HIGH(PRIO_HIGH)) u_prio (
        .req(remain),
        .idx(win_idx),
        .any(win_any)
    );

    // pending register, FSM and registered outputs all advance on one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            A     <= '0;
            V     <= 1'b0;
            Pend  <= '0;
        end else begin
            Pend <= remain | (En ? D : '0);
            if (state == IDLE || Rdy) begin
                if (win_any) begin
                    state <= HOLD;
                    A     <= win_idx;
                    V     <= 1'b1;
                end else begin
                    state <= IDLE;
                    V     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_enc4to2_serial.sv
// tb_enc4to2_serial: random and directed checks of both priority directions against a model
module tb_enc4to2_serial;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       En = 1'b0;
    logic [3:0] D = 4'b0000;
    logic       Rdy = 1'b0;
    logic [1:0] a_o [2];
    logic       v_o [2];
    logic [3:0] p_o [2];
    logic [3:0] m_pend [2] = '{4'b0, 4'b0};
    logic       m_v [2] = '{1'b0, 1'b0};
    logic [1:0] m_a [2] = '{2'b0, 2'b0};
    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    enc4to2_serial #(.PRIO_HIGH(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .En(En), .D(D), .Rdy(Rdy),
        .A(a_o[0]), .V(v_o[0]), .Pend(p_o[0])
    );
    enc4to2_serial #(.PRIO_HIGH(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .En(En), .D(D), .Rdy(Rdy),
        .A(a_o[1]), .V(v_o[1]), .Pend(p_o[1])
    );

    function automatic logic [1:0] win(input logic [3:0] p, input bit hi);
        logic [1:0] w = 2'd0;
        for (int k = 0; k < 4; k++)
            if (p[hi ? k : 3 - k]) w = 2'(hi ? k : 3 - k);
        return w;
    endfunction

    // reference: pending set of requests, one served per handshake
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i] <= 4'b0;
                m_v[i]    <= 1'b0;
                m_a[i]    <= 2'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [3:0] rem;
                rem = m_pend[i];
                if (m_v[i] && Rdy) rem[m_a[i]] = 1'b0;
                if (!m_v[i] || Rdy) begin
                    m_v[i] <= (rem != 4'b0);
                    if (rem != 4'b0) m_a[i] <= win(rem, i == 0);
                end
                m_pend[i] <= rem | (En ? D : 4'b0);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // every cycle: model vs both DUTs
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_pend%0d", i), p_o[i], m_pend[i]);
                chk($sformatf("model_v%0d", i), v_o[i], m_v[i]);
                if (m_v[i]) chk($sformatf("model_a%0d", i), a_o[i], m_a[i]);
            end
        end
    end

    task automatic step(input logic en, input logic [3:0] d, input logic rdy);
        En = en;
        D = d;
        Rdy = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_v", v_o[0], 0);
        chk("reset_a", a_o[0], 0);
        chk("reset_pend", p_o[0], 0);
        // single request
        step(1, 4'b0100, 1);
        chk("single_cap_v", v_o[0], 0);
        step(0, 4'b0000, 1);
        chk("single_v", v_o[0], 1);
        chk("single_a", a_o[0], 2);
        step(0, 4'b0000, 1);
        chk("single_done_v", v_o[0], 0);
        chk("single_done_pend", p_o[0], 0);
        // multi-hot drain, both directions
        step(1, 4'b1011, 1);
        step(0, 4'b0000, 1);
        chk("drain_h0", a_o[0], 3);
        chk("drain_l0", a_o[1], 0);
        step(0, 4'b0000, 1);
        chk("drain_h1", a_o[0], 1);
        chk("drain_l1", a_o[1], 1);
        step(0, 4'b0000, 1);
        chk("drain_h2", a_o[0], 0);
        chk("drain_l2", a_o[1], 3);
        chk("drain_v2", v_o[0], 1);
        step(0, 4'b0000, 1);
        chk("drain_end_v", v_o[0], 0);
        chk("drain_end_vl", v_o[1], 0);
        // backpressure with late higher-priority arrival
        step(1, 4'b0010, 0);
        step(0, 4'b0000, 0);
        step(1, 4'b1000, 0);
        step(0, 4'b0000, 0);
        step(0, 4'b0000, 0);
        chk("bp_a", a_o[0], 1);
        chk("bp_v", v_o[0], 1);
        chk("bp_pend", p_o[0], 4'b1010);
        step(0, 4'b0000, 1);
        chk("bp_next_a", a_o[0], 3);
        chk("bp_next_v", v_o[0], 1);
        step(0, 4'b0000, 1);
        chk("bp_end_v", v_o[0], 0);
        // set wins over clear
        step(1, 4'b0100, 0);
        step(0, 4'b0000, 0);
        chk("coll_a", a_o[0], 2);
        step(1, 4'b0100, 1);
        chk("coll_pend", p_o[0], 4'b0100);
        step(0, 4'b0000, 0);
        chk("coll_again_v", v_o[0], 1);
        chk("coll_again_a", a_o[0], 2);
        step(0, 4'b0000, 1);
        step(0, 4'b0000, 0);
        // capture disabled
        for (int k = 0; k < 3; k++) step(0, 4'b1111, 0);
        chk("en_pend", p_o[0], 0);
        chk("en_v", v_o[0], 0);
        // async reset between edges
        step(1, 4'b1100, 0);
        step(0, 4'b0000, 0);
        chk("pre_rst_pend", p_o[0], 4'b1100);
        chk("pre_rst_v", v_o[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_v", v_o[0], 0);
        chk("arst_a", a_o[0], 0);
        chk("arst_pend", p_o[0], 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(0, 4'b0000, 1);
        step(0, 4'b0000, 1);
        chk("post_rst_v", v_o[0], 0);
        chk("post_rst_pend", p_o[0], 0);
        // random traffic
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 2) != 0);
        for (int k = 0; k < 6; k++) step(0, 4'b0000, 1);
        chk("final_v", v_o[0] | v_o[1], 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
